real_stim_player: RTL
=====================

Name: real_stim_player

Overview:
- Stimulus source for emulated analog blocks: the drive-side counterpart of a real-valued probe.
- The host loads fixed-point samples over a valid/ready stream into an internal buffer, then plays them out as a real-valued signal.
- Each sample is held for a programmable number of cycles; playback is single-shot or looped.
- Output feeds a real input of an analog model (e.g. a filter's v_in) in place of a constant.

Parameters:
WIDTH, 25, bit width of signed fixed-point samples (value = code * 2^EXPONENT)
EXPONENT, -16, fixed-point exponent; metadata only, no arithmetic performed
DEPTH, 16, sample buffer entries; power of two, >= 2
HOLD_W, 16, width of hold_cycles

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
s_data  input  WIDTH  signed sample code to load
s_valid  input  1  s_data valid
s_ready  output  1  buffer accepts a sample this cycle
clear  input  1  empty the buffer (honoured in IDLE only)
start  input  1  begin playback (honoured in IDLE only)
abort  input  1  stop playback (honoured in PLAY only)
loop_en  input  1  replay from entry 0 after the last sample
hold_cycles  input  HOLD_W  each sample lasts hold_cycles+1 cycles
v_out  output  WIDTH  signed real-valued stimulus
busy  output  1  high in PLAY
done  output  1  one-cycle pulse when single-shot playback completes
count  output  $clog2(DEPTH)+1  number of loaded samples

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values: state=IDLE, count=0, v_out=0, busy=0, done=0. s_ready=0 while rst=1.
- States: IDLE, PLAY.

IDLE:
- s_ready = (count < DEPTH). Combinational from registered state and count.
- Beat accepted when s_valid & s_ready: write mem[count], count++.
- clear=1: count <- 0. clear takes priority over a same-cycle beat and over start.
- start=1 with count>0 -> PLAY next cycle. Same cycle: hold_cycles latched into hold_lat, rd_ptr<-0, hold_ctr<-0.
- start with count==0: ignored, no done pulse.
- A start coinciding with an accepted beat: the beat is written first, and playback includes it.
- v_out keeps its last value (0 after reset).

PLAY:
- s_ready=0. clear and start are ignored.
- Registered read path: start sampled at edge E0 -> v_out=mem[0] after edge E1.
- Each entry is visible on v_out for exactly hold_lat+1 cycles. hold_ctr counts 0..hold_lat, then rd_ptr advances.
- After the last entry (rd_ptr==count-1) completes its hold:
  - loop_en=1 (sampled at that cycle): rd_ptr<-0 with no gap cycle; mem[0] follows immediately.
  - loop_en=0: -> IDLE, done=1 for one cycle, v_out holds the last sample.
- abort=1: -> IDLE next cycle. v_out holds its current value, no done pulse, buffer contents and count retained.
- abort has priority over end-of-buffer in the same cycle.
- Reset mid-playback: all registers return to reset values. Buffer contents become don't-care since count=0.

Width rules:
- v_out is a direct copy of stored codes; no scaling or saturation.
- hold_lat is unsigned; hold_cycles=0 gives one sample per cycle.
- Changing hold_cycles during PLAY has no effect until the next start.

Optional Feature:
- Macro: STIM_PLAYER_LOOP_CNT_EN.
- Defined:
  - Adds output loop_cnt (16 bits, unsigned).
  - Increments each time a looped pass wraps rd_ptr to 0; saturates at 0xFFFF.
  - Cleared by rst and on each accepted start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Load 0x10000, -0x10000 (two's complement), 0x08000; hold_cycles=0, loop_en=0; pulse start at cycle t -> v_out=0x10000 at t+2, -0x10000 at t+3, 0x08000 at t+4; done=1 at t+5 only; busy high t+1..t+4; v_out stays 0x08000.
- Same buffer, hold_cycles=2 -> each value visible exactly 3 cycles; done 9 cycles after the first sample appears.
- DEPTH=16: stream 17 beats with s_valid held high -> s_ready drops after 16 accepts; count=16; 17th beat not taken. clear -> count=0, s_ready=1.
- loop_en=1, 2 samples A, B, hold 0 -> A,B,A,B,... with no gap and no done. Deassert loop_en -> finishes the current pass then done. With the macro defined, loop_cnt equals the number of wraps.
- Abort mid-sample B -> IDLE next cycle, v_out stays B, no done; count unchanged; re-start replays from A.
- start with count=0 -> stays IDLE, no done. Assert rst during PLAY -> next cycle v_out=0, busy=0, count=0, s_ready=1 after rst falls.

Source files
------------

// File: rtl/real_stim_player.sv
// Buffered real-valued stimulus player: loads signed fixed-point codes, then replays them with a programmable hold.
// Optional STIM_PLAYER_LOOP_CNT_EN adds a saturating loop_cnt output counting looped-pass wraps.
module real_stim_player #(
    parameter int WIDTH    = 25,
    parameter int EXPONENT = -16,
    parameter int DEPTH    = 16,
    parameter int HOLD_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [WIDTH-1:0]    s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       loop_en,
    input  logic [HOLD_W-1:0]          hold_cycles,
    output logic signed [WIDTH-1:0]    v_out,
    output logic                       busy,
    output logic                       done,
`ifdef STIM_PLAYER_LOOP_CNT_EN
    output logic [15:0]                loop_cnt,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (EXPONENT < -1024) || (EXPONENT > 1024)) begin : g_bad_param
        $error("real_stim_player: DEPTH must be a power of two >= 2 and EXPONENT within range");
    end

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t                     state, state_nx;
    logic [CW-1:0]              count_nx;
    logic [AW-1:0]              rd_ptr, rd_ptr_nx, rd_addr;
    logic [HOLD_W-1:0]          hold_lat, hold_lat_nx;
    logic [HOLD_W-1:0]          hold_ctr, hold_ctr_nx;
    logic                       primed, primed_nx;
    logic signed [WIDTH-1:0]    v_out_nx;
    logic                       done_nx;
    logic                       beat, we, last;
    logic signed [WIDTH-1:0]    mem [DEPTH];
`ifdef STIM_PLAYER_LOOP_CNT_EN
    logic [15:0]                loop_cnt_nx;
`endif

    assign s_ready = !rst && (state == IDLE) && (count < CW'(DEPTH));
    assign beat    = s_valid && s_ready;
    assign we      = beat && !clear;
    assign busy    = (state == PLAY);
    assign last    = (CW'(rd_ptr) == (count - CW'(1)));

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        rd_ptr_nx   = rd_ptr;
        rd_addr     = rd_ptr;
        hold_lat_nx = hold_lat;
        hold_ctr_nx = hold_ctr;
        primed_nx   = primed;
        v_out_nx    = v_out;
        done_nx     = 1'b0;
`ifdef STIM_PLAYER_LOOP_CNT_EN
        loop_cnt_nx = loop_cnt;
`endif
        case (state)
            IDLE: begin
                if (clear) begin
                    count_nx = '0;
                end else begin
                    if (beat) count_nx = count + CW'(1);
                    // post-write count so a same-cycle beat joins the playback
                    if (start && (count_nx != '0)) begin
                        state_nx    = PLAY;
                        hold_lat_nx = hold_cycles;
                        rd_ptr_nx   = '0;
                        hold_ctr_nx = '0;
                        primed_nx   = 1'b0;
`ifdef STIM_PLAYER_LOOP_CNT_EN
                        loop_cnt_nx = '0;
`endif
                    end
                end
            end
            PLAY: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (!primed) begin
                    // first PLAY cycle only fetches entry 0 into the output register
                    rd_addr     = '0;
                    v_out_nx    = mem[rd_addr];
                    primed_nx   = 1'b1;
                    hold_ctr_nx = '0;
                end else if (hold_ctr == hold_lat) begin
                    hold_ctr_nx = '0;
                    if (!last) begin
                        rd_ptr_nx = rd_ptr + AW'(1);
                        rd_addr   = rd_ptr + AW'(1);
                        v_out_nx  = mem[rd_addr];
                    end else if (loop_en) begin
                        rd_ptr_nx = '0;
                        rd_addr   = '0;
                        v_out_nx  = mem[rd_addr];
`ifdef STIM_PLAYER_LOOP_CNT_EN
                        if (loop_cnt != 16'hFFFF) loop_cnt_nx = loop_cnt + 16'd1;
`endif
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    hold_ctr_nx = hold_ctr + HOLD_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[count[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            hold_lat <= '0;
            hold_ctr <= '0;
            primed   <= 1'b0;
            v_out    <= '0;
            done     <= 1'b0;
`ifdef STIM_PLAYER_LOOP_CNT_EN
            loop_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            rd_ptr   <= rd_ptr_nx;
            hold_lat <= hold_lat_nx;
            hold_ctr <= hold_ctr_nx;
            primed   <= primed_nx;
            v_out    <= v_out_nx;
            done     <= done_nx;
`ifdef STIM_PLAYER_LOOP_CNT_EN
            loop_cnt <= loop_cnt_nx;
`endif
        end
    end

endmodule
